// File: rtl/rob_pkg.sv
// Shared ROB definitions: default sizes, pointer-width helper and head-action encoding.
// Imported by the ROB and reusable by the mapper and free list.
package rob_pkg;

   localparam int unsigned DEF_ARCHFILE_SIZE = 32;
   localparam int unsigned DEF_PHYSFILE_SIZE = 256;
   localparam int unsigned DEF_ROB_SIZE      = 128;

   // Index bits plus one wrap bit, so full and empty stay distinguishable.
   function automatic int unsigned rob_ptr_w(input int unsigned rob_size);
      return $clog2(rob_size) + 1;
   endfunction

   typedef enum logic [1:0] {
      HEAD_IDLE,
      HEAD_COMMIT,
      HEAD_FLUSH
   } head_act_e;

endpackage

// File: rtl/rob_ptr.sv
// Wrap-bit ROB pointer: increments modulo 2**PTR_W, with a clear that
// takes priority over the increment.
module rob_ptr #(
   parameter int unsigned PTR_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [PTR_W-1:0] ptr_q
);

   logic [PTR_W-1:0] ptr_d;

   // NOTE: combinational logic uses blocking '=' and assigns a default first, so no latch is inferred.
   always_comb begin
      ptr_d = ptr_q;
      if (clr) begin
         ptr_d = '0;
      end else if (inc) begin
         ptr_d = ptr_q + 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/rob_core.sv
// Reorder buffer: in-order allocation from dispatch, out-of-order completion,
// and in-order single-entry retire, with a full flush on an excepting head.
module rob_core
   import rob_pkg::*;
#(
   parameter int unsigned ARCHFILE_SIZE = DEF_ARCHFILE_SIZE,
   parameter int unsigned PHYSFILE_SIZE = DEF_PHYSFILE_SIZE,
   parameter int unsigned ROB_SIZE      = DEF_ROB_SIZE
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             alloc_rob,
   input  logic [$clog2(ARCHFILE_SIZE)-1:0] dest_arch_in,
   input  logic [$clog2(PHYSFILE_SIZE)-1:0] dest_phys_in,
   input  logic [$clog2(PHYSFILE_SIZE)-1:0] dest_oldphys_in,
   input  logic                             except_in,
   output logic                             rob_full,
   output logic [$clog2(ROB_SIZE)-1:0]      rob_entry_out,
   input  logic                             cmpl_valid,
   input  logic [$clog2(ROB_SIZE)-1:0]      cmpl_entry,
   input  logic                             cmpl_except,
   output logic                             retire_valid,
   output logic [$clog2(ARCHFILE_SIZE)-1:0] retire_arch,
   output logic [$clog2(PHYSFILE_SIZE)-1:0] retire_phys,
   output logic [$clog2(PHYSFILE_SIZE)-1:0] retire_oldphys,
   output logic                             flush_out,
   output logic [$clog2(ROB_SIZE)-1:0]      flush_entry
);

   localparam int unsigned AW   = $clog2(ARCHFILE_SIZE);
   localparam int unsigned PW   = $clog2(PHYSFILE_SIZE);
   localparam int unsigned IW   = $clog2(ROB_SIZE);
   localparam int unsigned PTRW = rob_ptr_w(ROB_SIZE);

   logic [PTRW-1:0]     head_q, tail_q;
   logic [IW-1:0]       head_idx, tail_idx;
   logic                empty, alloc_fire, cmpl_fire;
   head_act_e           head_act;

   logic [ROB_SIZE-1:0] valid_q, valid_d;
   logic [ROB_SIZE-1:0] done_q, done_d;
   logic [ROB_SIZE-1:0] except_q, except_d;

   logic [AW-1:0]       arch_mem    [ROB_SIZE];
   logic [PW-1:0]       phys_mem    [ROB_SIZE];
   logic [PW-1:0]       oldphys_mem [ROB_SIZE];

   logic                retire_valid_q, retire_valid_d;
   logic [AW-1:0]       retire_arch_q, retire_arch_d;
   logic [PW-1:0]       retire_phys_q, retire_phys_d;
   logic [PW-1:0]       retire_oldphys_q, retire_oldphys_d;
   logic                flush_q, flush_d;
   logic [IW-1:0]       flush_entry_q, flush_entry_d;

   assign head_idx      = head_q[IW-1:0];
   assign tail_idx      = tail_q[IW-1:0];
   assign empty         = (head_q == tail_q);
   assign rob_full      = (head_idx == tail_idx) && (head_q[IW] != tail_q[IW]);
   assign rob_entry_out = tail_idx;

   assign alloc_fire = alloc_rob && !rob_full;
   assign cmpl_fire  = cmpl_valid && valid_q[cmpl_entry]
                       && !(alloc_fire && (cmpl_entry == tail_idx));

   // Head decision looks only at registered state, so a same-cycle completion waits a cycle.
   always_comb begin
      head_act = HEAD_IDLE;
      if (!empty && valid_q[head_idx] && done_q[head_idx]) begin
         head_act = except_q[head_idx] ? HEAD_FLUSH : HEAD_COMMIT;
      end
   end

   rob_ptr #(.PTR_W(PTRW)) u_head_ptr (
      .clk   (clk),
      .rst   (rst),
      .clr   (head_act == HEAD_FLUSH),
      .inc   (head_act == HEAD_COMMIT),
      .ptr_q (head_q)
   );

   rob_ptr #(.PTR_W(PTRW)) u_tail_ptr (
      .clk   (clk),
      .rst   (rst),
      .clr   (head_act == HEAD_FLUSH),
      .inc   (alloc_fire),
      .ptr_q (tail_q)
   );

   always_comb begin
      valid_d  = valid_q;
      done_d   = done_q;
      except_d = except_q;
      if (head_act == HEAD_COMMIT) begin
         valid_d[head_idx] = 1'b0;
      end
      if (cmpl_fire) begin
         done_d[cmpl_entry]   = 1'b1;
         except_d[cmpl_entry] = except_q[cmpl_entry] | cmpl_except;
      end
      if (alloc_fire) begin
         valid_d[tail_idx]  = 1'b1;
         done_d[tail_idx]   = 1'b0;
         except_d[tail_idx] = except_in;
      end
      // Flush discards everything, including this cycle's allocation and completion.
      if (head_act == HEAD_FLUSH) begin
         valid_d  = '0;
         done_d   = '0;
         except_d = '0;
      end
   end

   always_comb begin
      retire_valid_d   = (head_act == HEAD_COMMIT);
      retire_arch_d    = retire_arch_q;
      retire_phys_d    = retire_phys_q;
      retire_oldphys_d = retire_oldphys_q;
      flush_d          = (head_act == HEAD_FLUSH);
      flush_entry_d    = flush_entry_q;
      if (head_act == HEAD_COMMIT) begin
         retire_arch_d    = arch_mem[head_idx];
         retire_phys_d    = phys_mem[head_idx];
         retire_oldphys_d = oldphys_mem[head_idx];
      end
      if (head_act == HEAD_FLUSH) begin
         flush_entry_d = head_idx;
      end
   end

   // NOTE: payload storage has no reset; valid bits decide whether a slot's contents mean anything.
   always_ff @(posedge clk) begin
      if (alloc_fire) begin
         arch_mem[tail_idx]    <= dest_arch_in;
         phys_mem[tail_idx]    <= dest_phys_in;
         oldphys_mem[tail_idx] <= dest_oldphys_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q          <= '0;
         done_q           <= '0;
         except_q         <= '0;
         retire_valid_q   <= 1'b0;
         retire_arch_q    <= '0;
         retire_phys_q    <= '0;
         retire_oldphys_q <= '0;
         flush_q          <= 1'b0;
         flush_entry_q    <= '0;
      end else begin
         valid_q          <= valid_d;
         done_q           <= done_d;
         except_q         <= except_d;
         retire_valid_q   <= retire_valid_d;
         retire_arch_q    <= retire_arch_d;
         retire_phys_q    <= retire_phys_d;
         retire_oldphys_q <= retire_oldphys_d;
         flush_q          <= flush_d;
         flush_entry_q    <= flush_entry_d;
      end
   end

   assign retire_valid   = retire_valid_q;
   assign retire_arch    = retire_arch_q;
   assign retire_phys    = retire_phys_q;
   assign retire_oldphys = retire_oldphys_q;
   assign flush_out      = flush_q;
   assign flush_entry    = flush_entry_q;

endmodule
